// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

   localparam int unsigned OPW = 5;

   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b00101;
   localparam logic [OPW-1:0] OP_OR   = 5'b00110;
   localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
   localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
   localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
   localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
   localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
   localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPW-1:0] OP_NOT  = 5'b10010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_IT  = 2'd1,
      ST_DIV_IT  = 2'd2,
      ST_DIV_FIX = 2'd3
   } alu_state_t;

   // flags = {Z, N, C, V}
   localparam int unsigned NFLAGS = 4;
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/seq_divider.sv
// Iterative signed divider (non-restoring on magnitudes), one quotient bit per cycle.
// Ports: clock, clear (async active-low), load (capture operands and start),
//        dividend/divisor (WIDTH), ready (high once all WIDTH iterations are done),
//        quotient_c/remainder_c (sign-corrected results, valid while ready).
// Divisor must be non-zero; the caller handles division by zero.
module seq_divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             ready,
   output logic [WIDTH-1:0] quotient_c,
   output logic [WIDTH-1:0] remainder_c
);

   // Partial remainder needs two extra bits: it spans [-2D, 2D) after the shift.
   localparam int unsigned PW = WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH);

   logic [PW-1:0]    prem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;
   logic             running;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] dvd_mag_c;
   logic [WIDTH-1:0] dvs_mag_c;
   logic [PW-1:0]    shifted_c;
   logic [PW-1:0]    step_c;
   logic [WIDTH-1:0] rem_mag_c;

   // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits unsigned.
   always_comb begin
      dvd_mag_c = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_mag_c = divisor[WIDTH-1]  ? -divisor  : divisor;
   end

   // One non-restoring step: add or subtract depending on the sign of the partial remainder.
   always_comb begin
      shifted_c = {prem[PW-2:0], quo[WIDTH-1]};
      step_c    = prem[PW-1] ? shifted_c + PW'(dvs) : shifted_c - PW'(dvs);
   end

   // Final correction: restore a negative remainder, then apply result signs.
   always_comb begin
      rem_mag_c   = prem[PW-1] ? WIDTH'(prem + PW'(dvs)) : prem[WIDTH-1:0];
      quotient_c  = neg_q ? -quo : quo;
      remainder_c = neg_r ? -rem_mag_c : rem_mag_c;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         prem    <= '0;
         quo     <= '0;
         dvs     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         running <= 1'b0;
         ready   <= 1'b0;
         cnt     <= '0;
      end else if (load) begin
         prem    <= '0;
         quo     <= dvd_mag_c;
         dvs     <= dvs_mag_c;
         neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         neg_r   <= dividend[WIDTH-1];
         running <= 1'b1;
         ready   <= 1'b0;
         cnt     <= '0;
      end else if (running) begin
         prem <= step_c;
         quo  <= {quo[WIDTH-2:0], ~step_c[PW-1]};
         cnt  <= cnt + CW'(1);
         if (cnt == CW'(WIDTH - 1)) begin
            running <= 1'b0;
            ready   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake, radix-4 Booth MUL and iterative DIV.
// Ports: clock, clear (async active-low), start, opcode (5), Ra/Rb (WIDTH operands),
//        Rc (2*WIDTH result), busy, done (1-cycle pulse), flags {Z,N,C,V}, div_zero.
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [OPW-1:0]     opcode,
   input  logic [WIDTH-1:0]   Ra,
   input  logic [WIDTH-1:0]   Rb,
   output logic [2*WIDTH-1:0] Rc,
   output logic               busy,
   output logic               done,
   output logic [NFLAGS-1:0]  flags,
   output logic               div_zero
);

   localparam int unsigned SHW  = $clog2(WIDTH);
   localparam int unsigned MSB  = WIDTH - 1;
   localparam int unsigned AW   = WIDTH + 2;
   localparam int unsigned CW   = $clog2(WIDTH);
   localparam int unsigned HALF = WIDTH / 2;

   alu_state_t       state;
   logic [CW-1:0]    cnt;

   // Booth registers: multiplicand, accumulator, multiplier and the appended q[-1] bit.
   logic [WIDTH-1:0] mcand;
   logic [AW-1:0]    acc;
   logic [WIDTH-1:0] mplr;
   logic             qm1;

   logic [AW-1:0]    m_ext_c;
   logic [AW-1:0]    pp_c;
   logic [AW-1:0]    sum_c;
   logic [AW-1:0]    acc_nxt_c;
   logic [WIDTH-1:0] mplr_nxt_c;

   logic [WIDTH:0]        add_c;
   logic [WIDTH-1:0]      sub_c;
   logic                  big_c;
   logic [SHW-1:0]        amt_c;
   logic [SHW-1:0]        rot_c;
   logic [WIDTH-1:0]      lo_c;
   logic [WIDTH-1:0]      hi_c;
   logic                  cy_c;
   logic                  ov_c;
   logic                  known_c;
   logic                  dz_c;
   logic [NFLAGS-1:0]     sc_flags_c;

   logic                  div_load_c;
   logic                  div_ready;
   logic [WIDTH-1:0]      div_quo_c;
   logic [WIDTH-1:0]      div_rem_c;

   function automatic logic [NFLAGS-1:0] zn_flags(input logic [WIDTH-1:0] v);
      logic [NFLAGS-1:0] f;
      f         = '0;
      f[FLAG_Z] = (v == '0);
      f[FLAG_N] = v[MSB];
      return f;
   endfunction

   // Radix-4 Booth recode of {mplr[1:0], qm1}, accumulate, then arithmetic shift by two.
   always_comb begin
      m_ext_c = {{2{mcand[MSB]}}, mcand};
      case ({mplr[1:0], qm1})
         3'b001, 3'b010: pp_c = m_ext_c;
         3'b011:         pp_c = AW'(m_ext_c << 1);
         3'b100:         pp_c = -AW'(m_ext_c << 1);
         3'b101, 3'b110: pp_c = -m_ext_c;
         default:        pp_c = '0;
      endcase
      sum_c      = acc + pp_c;
      acc_nxt_c  = {{2{sum_c[AW-1]}}, sum_c[AW-1:2]};
      mplr_nxt_c = {sum_c[1:0], mplr[WIDTH-1:2]};
   end

   // Single-cycle datapath (also produces the divide-by-zero result).
   always_comb begin
      add_c      = {1'b0, Ra} + {1'b0, Rb};
      sub_c      = Ra - Rb;
      big_c      = (Rb >= WIDTH'(WIDTH));
      amt_c      = Rb[SHW-1:0];
      rot_c      = SHW'(Rb % WIDTH'(WIDTH));
      lo_c       = '0;
      hi_c       = '0;
      cy_c       = 1'b0;
      ov_c       = 1'b0;
      known_c    = 1'b1;
      dz_c       = 1'b0;
      case (opcode)
         OP_ADD: begin
            lo_c = add_c[WIDTH-1:0];
            cy_c = add_c[WIDTH];
            ov_c = (Ra[MSB] == Rb[MSB]) && (add_c[MSB] != Ra[MSB]);
         end
         OP_SUB: begin
            lo_c = sub_c;
            cy_c = (Ra >= Rb);
            ov_c = (Ra[MSB] != Rb[MSB]) && (sub_c[MSB] != Ra[MSB]);
         end
         OP_AND:  lo_c = Ra & Rb;
         OP_OR:   lo_c = Ra | Rb;
         OP_SHR:  lo_c = big_c ? '0 : Ra >> amt_c;
         OP_SHRA: lo_c = big_c ? {WIDTH{Ra[MSB]}} : WIDTH'($signed(Ra) >>> amt_c);
         OP_SHL:  lo_c = big_c ? '0 : Ra << amt_c;
         // Rotates via a doubled operand so a zero amount needs no special case.
         OP_ROR:  lo_c = WIDTH'({Ra, Ra} >> rot_c);
         OP_ROL:  lo_c = WIDTH'(({Ra, Ra} << rot_c) >> WIDTH);
         OP_NEG:  lo_c = -Ra;
         OP_NOT:  lo_c = ~Ra;
         OP_DIV: begin
            lo_c = '1;
            hi_c = Ra;
            dz_c = 1'b1;
         end
         default: known_c = 1'b0;
      endcase
      sc_flags_c = '0;
      if (known_c) begin
         sc_flags_c         = zn_flags(lo_c);
         sc_flags_c[FLAG_C] = cy_c;
         sc_flags_c[FLAG_V] = ov_c;
      end
   end

   // Divider is loaded in the same edge that accepts a non-zero DIV.
   always_comb begin
      div_load_c = (state == ST_IDLE) && start && (opcode == OP_DIV) && (Rb != '0);
   end

   seq_divider #(
      .WIDTH (WIDTH)
   ) u_div (
      .clock       (clock),
      .clear       (clear),
      .load        (div_load_c),
      .dividend    (Ra),
      .divisor     (Rb),
      .ready       (div_ready),
      .quotient_c  (div_quo_c),
      .remainder_c (div_rem_c)
   );

   // Control FSM with registered outputs.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         mcand    <= '0;
         acc      <= '0;
         mplr     <= '0;
         qm1      <= 1'b0;
         Rc       <= '0;
         flags    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cnt <= '0;
                  if (opcode == OP_MUL) begin
                     mcand <= Ra;
                     acc   <= '0;
                     mplr  <= Rb;
                     qm1   <= 1'b0;
                     busy  <= 1'b1;
                     state <= ST_MUL_IT;
                  end else if ((opcode == OP_DIV) && (Rb != '0)) begin
                     busy  <= 1'b1;
                     state <= ST_DIV_IT;
                  end else begin
                     Rc       <= {hi_c, lo_c};
                     flags    <= sc_flags_c;
                     div_zero <= dz_c;
                     done     <= 1'b1;
                  end
               end
            end
            ST_MUL_IT: begin
               acc  <= acc_nxt_c;
               mplr <= mplr_nxt_c;
               qm1  <= mplr[1];
               cnt  <= cnt + CW'(1);
               if (cnt == CW'(HALF - 1)) begin
                  Rc       <= {acc_nxt_c[WIDTH-1:0], mplr_nxt_c};
                  flags    <= zn_flags(mplr_nxt_c);
                  div_zero <= 1'b0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            ST_DIV_IT: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= ST_DIV_FIX;
               end
            end
            ST_DIV_FIX: begin
               if (div_ready) begin
                  Rc       <= {div_rem_c, div_quo_c};
                  flags    <= zn_flags(div_quo_c);
                  div_zero <= 1'b0;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32): stimulus pushes model results, a monitor checks each done.
module tb_seq_alu;

   localparam int unsigned W = 32;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   logic           clock = 1'b0;
   logic           clear;
   logic           start;
   logic [4:0]     opcode;
   logic [W-1:0]   Ra;
   logic [W-1:0]   Rb;
   logic [2*W-1:0] Rc;
   logic           busy;
   logic           done;
   logic [3:0]     flags;
   logic           div_zero;

   seq_alu #(.WIDTH(W)) dut (
      .clock    (clock),
      .clear    (clear),
      .start    (start),
      .opcode   (opcode),
      .Ra       (Ra),
      .Rb       (Rb),
      .Rc       (Rc),
      .busy     (busy),
      .done     (done),
      .flags    (flags),
      .div_zero (div_zero)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] rc;
      logic [3:0]  flags;
      logic        dz;
      int unsigned lat;
      longint      edge_idx;
   } exp_t;

   exp_t   sb_q[$];
   int     checks = 0;
   int     errors = 0;
   longint edge_cnt = 0;

   logic [4:0] ops [13] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
                            OP_ROR, OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT};

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] lo;
      logic [63:0] ua;
      logic        c;
      logic        v;
      bit          known;
      longint      sa;
      longint      sb;
      longint      s;
      longint      q;
      longint      r;
      int          rr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.rc = '0; e.dz = 1'b0; e.lat = 1; e.edge_idx = 0;
      c = 1'b0; v = 1'b0; known = 1'b1; lo = '0;
      rr = int'(b % 32);
      case (op)
         OP_ADD: begin
            ua = {32'h0, a} + {32'h0, b};
            lo = ua[31:0]; c = ua[32];
            s = sa + sb; v = (s != longint'($signed(lo)));
         end
         OP_SUB: begin
            lo = a - b; c = (a >= b);
            s = sa - sb; v = (s != longint'($signed(lo)));
         end
         OP_AND:  lo = a & b;
         OP_OR:   lo = a | b;
         OP_SHR:  lo = a >> b;
         OP_SHRA: lo = $signed(a) >>> b;
         OP_SHL:  lo = a << b;
         OP_ROR:  lo = (a >> rr) | (a << (32 - rr));
         OP_ROL:  lo = (a << rr) | (a >> (32 - rr));
         OP_NEG:  lo = -a;
         OP_NOT:  lo = ~a;
         OP_MUL: begin
            s = sa * sb;
            e.rc = s; lo = s[31:0]; e.lat = 17;
         end
         OP_DIV: begin
            if (b == 0) begin
               lo = 32'hFFFF_FFFF; e.rc = {a, lo}; e.dz = 1'b1;
            end else begin
               q = sa / sb; r = sa % sb;
               lo = q[31:0]; e.rc = {r[31:0], q[31:0]}; e.lat = 34;
            end
         end
         default: known = 1'b0;
      endcase
      if (op != OP_MUL && op != OP_DIV) e.rc = {32'h0, lo};
      e.flags = known ? {lo == 0, lo[31], c, v} : 4'b0000;
      return e;
   endfunction

   // Monitor: every done must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (clear === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done: got done=1 with no operation outstanding");
            end else begin
               e = sb_q.pop_front();
               chk("rc", Rc, e.rc);
               chk("flags", 64'(flags), 64'(e.flags));
               chk("div_zero", 64'(div_zero), 64'(e.dz));
               chk("latency", 64'(edge_cnt - e.edge_idx + 1), 64'(e.lat));
            end
         end
      end
   end

   // Issue one op (called at a negedge); returns at the negedge where done is seen.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
      exp_t e;
      int   busy_n;
      bit   seen;
      e = model(op, a, b);
      opcode = op; Ra = a; Rb = b; start = 1'b1;
      @(posedge clock); #1;
      e.edge_idx = edge_cnt;
      sb_q.push_back(e);
      start = 1'b0; opcode = 5'($urandom); Ra = $urandom; Rb = $urandom;
      busy_n = 0; seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clock);
         if (done) seen = 1'b1;
         else begin
            if (busy) busy_n++;
            start  = poke && (i == 3);
            opcode = start ? OP_ADD : 5'($urandom);
            Ra = $urandom; Rb = $urandom;
         end
      end
      start = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout: got no done within 100 cycles, expected done after %0d", e.lat);
      end
      chk("busy_cycles", 64'(busy_n), 64'(e.lat - 1));
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      clear = 1'b1; start = 1'b0; opcode = '0; Ra = '0; Rb = '0;
      #2 clear = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_rc", Rc, 64'h0);
      chk("rst_flags", 64'(flags), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_done", 64'(done), 64'h0);
      chk("rst_div_zero", 64'(div_zero), 64'h0);
      clear = 1'b1;

      run_op(OP_ADD,  32'h7FFF_FFFF, 32'h1, 1'b0);
      run_op(OP_MUL,  32'hFFFF_FFFD, 32'h7, 1'b1);
      run_op(OP_MUL,  32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op(OP_DIV,  32'hFFFF_FFF9, 32'h2, 1'b0);
      run_op(OP_DIV,  32'h5, 32'h0, 1'b0);
      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      run_op(OP_DIV,  32'h7, 32'hFFFF_FFFE, 1'b0);
      run_op(OP_SHRA, 32'h8000_0000, 32'd40, 1'b0);
      run_op(OP_SHL,  32'h1, 32'd32, 1'b0);
      run_op(OP_ROL,  32'h8000_0001, 32'd33, 1'b0);
      run_op(OP_ROR,  32'h8000_0001, 32'd0, 1'b0);
      run_op(OP_NEG,  32'h8000_0000, 32'h0, 1'b0);
      run_op(OP_SUB,  32'h0, 32'h1, 1'b0);
      run_op(OP_SUB,  32'h8000_0000, 32'h1, 1'b0);
      run_op(5'b11111, 32'h1, 32'h2, 1'b0);

      for (int n = 0; n < 200; n++) begin
         logic [4:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 12)];
         a  = pick_val();
         if (op >= OP_SHR && op <= OP_ROL && $urandom_range(0, 1) == 1) b = $urandom_range(0, 40);
         else b = pick_val();
         run_op(op, a, b, ($urandom_range(0, 3) == 0));
      end

      // Abort a DIV mid-iteration; outputs must drop immediately and nothing may complete.
      opcode = OP_DIV; Ra = 32'h1234_5678; Rb = 32'h3; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #2 clear = 1'b0;
      #1;
      chk("abort_rc", Rc, 64'h0);
      chk("abort_flags", 64'(flags), 64'h0);
      chk("abort_busy", 64'(busy), 64'h0);
      chk("abort_done", 64'(done), 64'h0);
      chk("abort_div_zero", 64'(div_zero), 64'h0);
      @(negedge clock);
      clear = 1'b1;
      run_op(OP_DIV, 32'hFFFF_FF9C, 32'h7, 1'b0);
      run_op(OP_MUL, 32'h0001_0003, 32'hFFFF_0005, 1'b0);
      run_op(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);

      repeat (5) @(negedge clock);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
